// File: rtl/lab62soc_out_pio_if.sv
// rtl/lab62soc_out_pio_if.sv - Avalon-MM slave register bus for the output PIO
interface lab62soc_out_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/lab62soc_out_pio.sv
// rtl/lab62soc_out_pio.sv - output PIO with data, set/clear and one-shot pulse registers
module lab62soc_out_pio #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    lab62soc_out_pio_if.slave avs,
    output logic [WIDTH-1:0]  out_port
);
    typedef enum logic [2:0] {
        ADDR_DATA      = 3'd0,
        ADDR_RSVD1     = 3'd1,
        ADDR_PULSE_LEN = 3'd2,
        ADDR_PULSE     = 3'd3,
        ADDR_OUTSET    = 3'd4,
        ADDR_OUTCLEAR  = 3'd5,
        ADDR_RSVD6     = 3'd6,
        ADDR_RSVD7     = 3'd7
    } addr_e;

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_mask;
    logic [15:0]      r_plen;
    logic [15:0]      r_pcount;
    logic [31:0]      r_readdata;

    addr_e            w_addr;
    logic             w_wr;
    logic             w_pulse_go;
    logic [WIDTH-1:0] w_wdata;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_addr     = addr_e'(avs.address);
    assign w_wr       = avs.chipselect && !avs.write_n;
    assign w_wdata    = avs.writedata[WIDTH-1:0];
    // A PULSE write with zero length is treated as if no write happened.
    assign w_pulse_go = w_wr && (w_addr == ADDR_PULSE) && (r_plen != 16'd0);
    assign w_unused   = ^avs.writedata;

    always_comb begin
        w_rdata = 32'd0;
        case (w_addr)
            ADDR_DATA:      w_rdata = 32'(r_data);
            ADDR_PULSE_LEN: w_rdata = 32'(r_plen);
            ADDR_PULSE:     w_rdata = 32'(r_mask);
            default:        w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= RESET_VALUE;
            r_mask     <= '0;
            r_plen     <= 16'd0;
            r_pcount   <= 16'd0;
            r_readdata <= 32'd0;
        end else begin
            r_readdata <= w_rdata;

            if (w_wr) begin
                case (w_addr)
                    ADDR_DATA:      r_data <= w_wdata;
                    ADDR_OUTSET:    r_data <= r_data | w_wdata;
                    ADDR_OUTCLEAR:  r_data <= r_data & ~w_wdata;
                    ADDR_PULSE_LEN: r_plen <= avs.writedata[15:0];
                    default:        ;
                endcase
            end

            // Retrigger beats decrement and expiry, stretching every live bit.
            if (w_pulse_go) begin
                r_mask   <= r_mask | w_wdata;
                r_pcount <= r_plen;
            end else if (r_pcount > 16'd1) begin
                r_pcount <= r_pcount - 16'd1;
            end else if (r_pcount == 16'd1) begin
                r_pcount <= 16'd0;
                r_mask   <= '0;
            end
        end
    end

    assign avs.readdata = r_readdata;
    assign out_port     = r_data | r_mask;
endmodule

// File: tb/tb_lab62soc_out_pio.sv
// tb/tb_lab62soc_out_pio.sv - scoreboard bench for lab62soc_out_pio
module tb_lab62soc_out_pio;
    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] out_port;

    lab62soc_out_pio_if bus ();

    lab62soc_out_pio #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .clk      (clk),
        .reset    (reset),
        .avs      (bus.slave),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  q_out[$];
    logic [31:0] q_rd[$];
    string       q_tag[$];

    // Model: pulse bits are visible after edge e while e < m_expire.
    int          m_edge   = 0;
    int          m_expire = 0;
    logic [7:0]  m_data   = '0;
    logic [7:0]  m_mask   = '0;
    logic [15:0] m_plen   = '0;

    function automatic logic [7:0] vis(input int e);
        return (e < m_expire) ? m_mask : 8'h00;
    endfunction

    task automatic cyc(input bit rst, input bit cs, input bit wn,
                       input logic [2:0] a, input logic [31:0] wd, input string tag);
        logic [31:0] rd;
        logic [7:0]  pre;
        @(negedge clk);
        reset          = rst;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = a;
        bus.writedata  = wd;
        m_edge++;
        if (rst) begin
            m_data = RV; m_plen = '0; m_mask = '0; m_expire = 0; rd = '0;
        end else begin
            pre = vis(m_edge - 1);
            case (a)
                3'd0:    rd = {24'd0, m_data};
                3'd2:    rd = {16'd0, m_plen};
                3'd3:    rd = {24'd0, pre};
                default: rd = 32'd0;
            endcase
            if (cs && !wn) begin
                case (a)
                    3'd0: m_data = wd[7:0];
                    3'd2: m_plen = wd[15:0];
                    3'd3: if (m_plen != 0) begin
                        m_mask   = pre | wd[7:0];
                        m_expire = m_edge + int'(m_plen);
                    end
                    3'd4: m_data = m_data | wd[7:0];
                    3'd5: m_data = m_data & ~wd[7:0];
                    default: ;
                endcase
            end
        end
        q_out.push_back(m_data | vis(m_edge));
        q_rd.push_back(rd);
        q_tag.push_back(tag);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd, input string tag);
        cyc(1'b0, 1'b1, 1'b0, a, wd, tag);
    endtask

    task automatic idle(input logic [2:0] a, input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, a, $urandom, tag);
    endtask

    initial begin : monitor
        logic [7:0]  eo;
        logic [31:0] er;
        string       t;
        forever begin
            @(posedge clk);
            #1;
            if (q_out.size() > 0) begin
                eo = q_out.pop_front();
                er = q_rd.pop_front();
                t  = q_tag.pop_front();
                n_tests += 2;
                if (out_port !== eo) begin
                    n_fail++;
                    $display("FAIL %s out_port got %h expected %h", t, out_port, eo);
                end
                if (bus.readdata !== er) begin
                    n_fail++;
                    $display("FAIL %s readdata got %h expected %h", t, bus.readdata, er);
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] wd;
        int          r;
        reset = 1'b1; bus.chipselect = 1'b0; bus.write_n = 1'b1;
        bus.address = '0; bus.writedata = '0;

        cyc(1'b1, 1'b0, 1'b1, 3'd0, 32'd0, "reset");
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 32'hFF, "reset_wr_discard");
        idle(3'd0, 1, "reset_read");

        wr(3'd0, 32'h0F, "data_wr");
        wr(3'd4, 32'h30, "outset");
        wr(3'd5, 32'h03, "outclear");
        idle(3'd0, 1, "setclr_read");
        idle(3'd4, 1, "read_outset");
        idle(3'd5, 1, "read_outclear");
        idle(3'd1, 1, "read_rsvd");

        wr(3'd2, 32'd5, "plen5");
        wr(3'd0, 32'h00, "data0");
        wr(3'd3, 32'h80, "pulse80");
        idle(3'd3, 7, "single_pulse");

        wr(3'd2, 32'd4, "plen4");
        wr(3'd3, 32'h01, "retrig_a");
        idle(3'd3, 2, "retrig_gap");
        wr(3'd3, 32'h02, "retrig_b");
        idle(3'd3, 6, "retrig_tail");

        wr(3'd2, 32'd0, "plen0");
        wr(3'd3, 32'hFF, "pulse_len0");
        idle(3'd3, 2, "len0_idle");
        wr(3'd2, 32'd3, "plen3");
        wr(3'd3, 32'h04, "exp_a");
        idle(3'd3, 2, "exp_gap");
        wr(3'd3, 32'h08, "exp_retrig");
        idle(3'd3, 5, "exp_tail");
        wr(3'd2, 32'h0001_0007, "plen_trunc");
        idle(3'd2, 1, "plen_read");

        wr(3'd2, 32'd100, "plen100");
        wr(3'd3, 32'h10, "long_pulse");
        idle(3'd3, 9, "long_active");
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 32'h3C, "mid_reset");
        idle(3'd3, 2, "after_reset");

        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            wd = $urandom;
            if (r < 2) begin
                cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), wd, "rand_reset");
            end else begin
                logic [2:0] a;
                a = 3'($urandom_range(0, 7));
                if (a == 3'd2) wd = (wd & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
                if (a == 3'd3 && $urandom_range(0, 1) == 1) wd = wd & 32'h0000_0011;
                cyc(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, wd, "random");
            end
        end

        for (int i = 0; i < 5 && q_out.size() > 0; i++) @(posedge clk);
        #2;
        if (q_out.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain %0d entries left expected 0", q_out.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lab62soc_out_pio.md
# lab62soc_out_pio

Avalon-MM slave output port for the lab62soc system. It is the write-side counterpart of the read-only key/switch input ports, and drives LEDs or other board outputs from the Nios II. The block provides a data register plus atomic bit-set and bit-clear registers. It also supports a one-shot pulse facility: selected output bits are asserted for a programmed number of clock cycles and then released by hardware.

## Interface

**Parameters**
- `WIDTH`, default 8: width of `out_port` and of the data/mask registers (1..32).
- `RESET_VALUE`, default 0: value loaded into the data register on reset.

**Ports**
- `clk` (in, 1): system clock. Everything is single clock.
- `reset` (in, 1): synchronous, active-high reset.
- `address` (in, 3): word address of the register.
- `chipselect` (in, 1): slave select.
- `write_n` (in, 1): active-low write strobe. A write happens when `chipselect && !write_n`.
- `writedata` (in, 32): write data. Only bits [WIDTH-1:0] are used, except for PULSE_LEN.
- `readdata` (out, 32): registered read data, zero-extended.
- `out_port` (out, WIDTH): output pins.

## Operation

**Register map (word addresses)**
- 0 DATA, R/W: software output value.
- 1: reserved. Reads 0; writes are ignored.
- 2 PULSE_LEN, R/W, 16 bits (`writedata[15:0]`): pulse duration in cycles.
- 3 PULSE, W/R: writing starts a pulse on every bit that is 1 in `writedata`. Reading returns the current pulse mask.
- 4 OUTSET, W: `DATA <= DATA | writedata[WIDTH-1:0]`. Reads 0.
- 5 OUTCLEAR, W: `DATA <= DATA & ~writedata[WIDTH-1:0]`. Reads 0.
- 6, 7: reserved. Reads 0; writes are ignored.

**Output**
- `out_port = DATA | pulse_mask`, combinational from registers. No glitching logic sits in the path.

**Pulse engine**
- One shared 16-bit down-counter `pcount` and one WIDTH-bit `pulse_mask`.
- Write to PULSE with PULSE_LEN = L > 0:
  - `pulse_mask <= pulse_mask | writedata[WIDTH-1:0]`
  - `pcount <= L`
- Write to PULSE with PULSE_LEN = 0: ignored. Mask and counter are unchanged.
- Each cycle with `pcount > 1` and no PULSE write: `pcount <= pcount - 1`.
- Cycle with `pcount == 1` and no PULSE write: `pcount <= 0`, `pulse_mask <= 0`.
- `pcount == 0`: idle. `pulse_mask` is 0.
- Retrigger while active: the PULSE write wins over both decrement and expiry. New bits are ORed in, and every active bit is extended to L cycles from the new write.
- Writing PULSE_LEN while a pulse is active does not affect `pcount` in flight.
- States are derived from `pcount`: IDLE (`pcount == 0`) and ACTIVE (`pcount != 0`).

**Read path**
- `readdata <= zero_extend(mux(address))` every clock, regardless of `chipselect`. This gives a fixed 1-cycle read latency and no wait states.
- Read values by address:
  - DATA → `DATA`
  - PULSE_LEN → `{16'b0, PULSE_LEN}`
  - PULSE → `pulse_mask`
  - all others → 0

**Reset (synchronous, highest priority)**
- `DATA = RESET_VALUE`
- `PULSE_LEN = 0`, `pulse_mask = 0`, `pcount = 0`
- `readdata = 0`
- Therefore `out_port = RESET_VALUE`.
- Reset asserted mid-pulse ends the pulse on the next edge. A write in the same cycle as reset is discarded.

## Timing

- Write accepted at rising edge N. `DATA`/`out_port` reflect it from edge N onward, i.e. visible in cycle N+1. Zero wait states.
- Pulse written at edge N with L: the pulse bits are high for exactly L cycles (edges N..N+L-1) and low after edge N+L.
- `address` sampled at edge N: `readdata` is valid after edge N. The master uses readLatency = 1.
- Only one register is written per cycle. An OUTSET/OUTCLEAR write during an active pulse changes `DATA` only. The pulsed bit stays high until expiry, even if cleared in `DATA`.

## Test plan

1. **Reset value.** `RESET_VALUE=8'hA5`, assert `reset` for 2 cycles → `out_port=8'hA5`, `readdata=0`. Read addr 0 → `0x000000A5`.
2. **Set and clear.** Write DATA=`0x0F`, OUTSET `0x30`, OUTCLEAR `0x03` → `out_port=0x3C`. Reads of addr 4 and 5 return 0.
3. **Single pulse.** PULSE_LEN=5, DATA=0, write PULSE `0x80` → `out_port[7]` high for exactly 5 cycles. Read addr 3 returns `0x80` during the pulse and 0 after.
4. **Retrigger.** PULSE_LEN=4, write PULSE `0x01`, then 2 cycles later write PULSE `0x02` → bits 0 and 1 are both high and fall together 4 cycles after the second write. Bit 0 is high for 6 cycles total.
5. **Edge cases.**
   - PULSE_LEN=0, write PULSE `0xFF` → `out_port` unchanged.
   - Write PULSE at the exact expiry cycle → the pulse continues with no low cycle.
   - Write PULSE_LEN `0x1_0007` → reads back `0x0007`.
6. **Reset mid-pulse.** PULSE_LEN=100, pulse `0x10`, assert `reset` at cycle 10 → `out_port=RESET_VALUE` next cycle, and addr 3 reads 0 after reset.
